// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data memory (dmem_ram) and the LSU:
//   - dmem_state_e : controller states (post-reset clear sweep / normal run)
//   - RSP_OKAY / RSP_ERROR : response codes carried on err_o
//   - clog2() : elaboration-time ceil(log2(n)) helper
// -----------------------------------------------------------------------------
package dmem_pkg;

  // Controller state: CLEAR zeroes the array word by word, RUN serves requests.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } dmem_state_e;

  // Response codes as seen by the LSU on err_o (qualified by rvalid_o).
  localparam logic RSP_OKAY  = 1'b0;
  localparam logic RSP_ERROR = 1'b1;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned remain;
    result = 0;
    remain = (value > 0) ? value - 1 : 0;
    while (remain > 0) begin
      result = result + 1;
      remain = remain >> 1;
    end
    return result;
  endfunction

endpackage : dmem_pkg

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Word-organised storage with per-byte write enables and a registered read
// port. One access per cycle: a write (en_i & we_i) or a read (en_i & ~we_i).
// Ports:
//   clk_i    clock, rising edge
//   en_i     access enable
//   we_i     1 = write selected byte lanes, 0 = read word into rdata_o
//   be_i     byte-lane write enables
//   idx_i    word index
//   wdata_i  lane-aligned write data
//   rdata_o  registered read data (holds its value when no read is issued)
// -----------------------------------------------------------------------------
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned BYTES      = DATA_WIDTH / 8,
  parameter int unsigned IDX_W      = clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [BYTES-1:0]      be_i,
  input  logic [IDX_W-1:0]      idx_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage and read register. No reset here on purpose: the array is a RAM
  // and its contents must survive reset; the controller masks rdata when it
  // is not a valid read response.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < BYTES; b++) begin
          if (be_i[b]) begin
            mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule : dmem_array

// File: rtl/dmem_ram.sv
// -----------------------------------------------------------------------------
// dmem_ram
// Single-port data memory for the load/store path with byte strobes, a
// req/gnt/rvalid handshake, one-cycle registered responses, error responses
// for misaligned / out-of-range accesses and an optional post-reset clear
// sweep that zeroes every word before the first grant.
// Ports:
//   clk_i     clock, rising edge
//   rst_ni    synchronous active-low reset
//   req_i     access request
//   we_i      1 = write, 0 = read
//   be_i      byte-lane write enables (ignored on reads)
//   addr_i    byte address
//   wdata_i   lane-aligned write data
//   gnt_o     request accepted this cycle (combinational)
//   rvalid_o  response valid, exactly one cycle after each grant
//   rdata_o   read data (zero unless the response is a legal read)
//   err_o     error response, qualified by rvalid_o
//   busy_o    clear sweep in progress (combinational)
// -----------------------------------------------------------------------------
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DEPTH          = 4096,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    gnt_o,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  output logic                    busy_o
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFS   = clog2(BYTES);
  localparam int unsigned IDX_W = clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned HI_LSB = OFS + IDX_W;

  localparam logic [CNT_W-1:0]      CLR_LAST   = CNT_W'(DEPTH - 1);
  // Byte-offset bits inside a word; a nonzero offset means misaligned.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << OFS) - 64'd1);

  dmem_state_e      state_q, state_d;
  logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             rvalid_q, rvalid_d;
  logic             err_q, err_d;
  logic             rd_q, rd_d;

  logic             in_clear;
  logic             misaligned;
  logic             out_of_range;
  logic             gnt;
  logic             legal;
  logic [IDX_W-1:0] req_idx;

  logic                  arr_en;
  logic                  arr_we;
  logic [BYTES-1:0]      arr_be;
  logic [IDX_W-1:0]      arr_idx;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [DATA_WIDTH-1:0] arr_rdata;

  // Address decode and request classification. Any address bit above the
  // word index makes the access out of range.
  always_comb begin
    in_clear     = (state_q == ST_CLEAR);
    misaligned   = |(addr_i & ALIGN_MASK);
    out_of_range = |(addr_i >> HI_LSB);
    req_idx      = addr_i[OFS +: IDX_W];
    gnt          = req_i & ~in_clear;
    legal        = gnt & ~misaligned & ~out_of_range;
  end

  assign gnt_o  = gnt;
  assign busy_o = in_clear;

  // Array port steering: the clear sweep owns the port in CLEAR, otherwise
  // only legal granted accesses reach it. Writes are held off while reset is
  // asserted so reset never disturbs the array contents.
  always_comb begin
    arr_en    = rst_ni & (in_clear | legal);
    arr_we    = in_clear | we_i;
    arr_be    = in_clear ? {BYTES{1'b1}} : be_i;
    arr_idx   = in_clear ? clr_cnt_q[IDX_W-1:0] : req_idx;
    arr_wdata = in_clear ? '0 : wdata_i;
  end

  dmem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .BYTES      (BYTES),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .en_i    (arr_en),
    .we_i    (arr_we),
    .be_i    (arr_be),
    .idx_i   (arr_idx),
    .wdata_i (arr_wdata),
    .rdata_o (arr_rdata)
  );

  // Next-state logic: the sweep counter advances once per CLEAR cycle and
  // hands over to RUN after the last word; every grant produces a response
  // on the following cycle.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (in_clear) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == CLR_LAST) begin
        state_d = ST_RUN;
      end
    end
    rvalid_d = gnt;
    err_d    = gnt & ~legal ? RSP_ERROR : RSP_OKAY;
    rd_d     = legal & ~we_i;
  end

  // Controller and response registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_cnt_q <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= RSP_OKAY;
      rd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      rd_q      <= rd_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  // The read register is only meaningful for a legal read response.
  assign rdata_o  = rd_q ? arr_rdata : '0;

endmodule : dmem_ram

// File: tb/tb_dmem_ram.sv
// -----------------------------------------------------------------------------
// tb_dmem_ram
// Self-checking bench for dmem_ram (DEPTH=16, 32-bit data/address).
// dutClr runs with the clear sweep enabled, dutKeep with it disabled.
// Expected responses come from a table of hand-computed vectors and from a
// byte-addressed reference memory for the random phase.
// -----------------------------------------------------------------------------
module tb_dmem_ram;

  localparam int DEPTH    = 16;
  localparam int MEMBYTES = DEPTH * 4;

  logic        clk;
  logic        clrRstN, reqI, weI;
  logic [3:0]  beI;
  logic [31:0] addrI, wdataI;
  logic        gnt, rvalid, err, busy;
  logic [31:0] rdata;

  logic        keepRstN, keepReq, keepWe;
  logic [3:0]  keepBe;
  logic [31:0] keepAddr, keepWdata;
  logic        keepGnt, keepRvalid, keepErr, keepBusy;
  logic [31:0] keepRdata;

  int checkCount = 0;
  int failCount  = 0;

  byte unsigned modelMem [MEMBYTES];

  typedef struct {
    bit          req;
    bit          we;
    bit [3:0]    be;
    bit [31:0]   addr;
    bit [31:0]   wdata;
    bit          expErr;
    bit [31:0]   expRdata;
    string       name;
  } vec_t;

  vec_t vecs [14];

  dmem_ram #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)
  ) dutClr (
    .clk_i(clk), .rst_ni(clrRstN), .req_i(reqI), .we_i(weI), .be_i(beI),
    .addr_i(addrI), .wdata_i(wdataI), .gnt_o(gnt), .rvalid_o(rvalid),
    .rdata_o(rdata), .err_o(err), .busy_o(busy)
  );

  dmem_ram #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .CLEAR_ON_RESET(1'b0)
  ) dutKeep (
    .clk_i(clk), .rst_ni(keepRstN), .req_i(keepReq), .we_i(keepWe), .be_i(keepBe),
    .addr_i(keepAddr), .wdata_i(keepWdata), .gnt_o(keepGnt), .rvalid_o(keepRvalid),
    .rdata_o(keepRdata), .err_o(keepErr), .busy_o(keepBusy)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic vec_t mkVec(input bit req, input bit we, input bit [3:0] be,
                                 input bit [31:0] addr, input bit [31:0] wdata,
                                 input bit expErr, input bit [31:0] expRdata,
                                 input string name);
    vec_t v;
    v.req = req; v.we = we; v.be = be; v.addr = addr; v.wdata = wdata;
    v.expErr = expErr; v.expRdata = expRdata; v.name = name;
    return v;
  endfunction

  function automatic void modelClear();
    for (int i = 0; i < MEMBYTES; i++) modelMem[i] = 8'h00;
  endfunction

  // Reference behaviour: little-endian byte memory of MEMBYTES bytes; only
  // word-aligned byte addresses below MEMBYTES are legal.
  function automatic void modelAccess(input bit we, input bit [3:0] be,
                                      input bit [31:0] addr, input bit [31:0] wdata,
                                      output bit expErr, output bit [31:0] expRdata);
    expErr   = (addr % 4 != 0) || (addr >= MEMBYTES);
    expRdata = 32'h0;
    if (!expErr) begin
      for (int b = 0; b < 4; b++) begin
        if (we && be[b]) modelMem[int'(addr) + b] = wdata[8*b +: 8];
        if (!we) expRdata[8*b +: 8] = modelMem[int'(addr) + b];
      end
    end
  endfunction

  // Drives one request cycle on dutClr (called just after a rising edge),
  // captures gnt mid-cycle, then returns #1 after the grant edge so the
  // registered response is visible.
  task automatic applyStimulus(input bit req, input bit we, input bit [3:0] be,
                               input bit [31:0] addr, input bit [31:0] wdata,
                               output bit gntSeen);
    reqI = req; weI = we; beI = be; addrI = addr; wdataI = wdata;
    #1;
    gntSeen = gnt;
    @(posedge clk);
    #1;
  endtask

  // Releases dutClr reset and measures the busy window, bounded to 40 cycles.
  task automatic runSweep(input string name);
    int cycles;
    cycles = 0;
    reqI = 1'b1; weI = 1'b0; beI = 4'hF; addrI = 32'h0; wdataI = 32'h0;
    clrRstN = 1'b1;
    #1;
    while (busy && cycles < 40) begin
      checkOutput({name, " gnt during sweep"}, 32'(gnt), 32'd0);
      @(posedge clk);
      #1;
      checkOutput({name, " rvalid during sweep"}, 32'(rvalid), 32'd0);
      cycles++;
    end
    checkOutput({name, " busy cycles"}, 32'(cycles), 32'd16);
    reqI = 1'b0;
    modelClear();
  endtask

  initial begin
    bit        gntSeen;
    bit        expErr;
    bit [31:0] expRdata;
    bit        rReq, rWe;
    bit [3:0]  rBe;
    bit [31:0] rAddr, rWdata;

    clrRstN = 1'b0; reqI = 1'b1; weI = 1'b0; beI = 4'h0; addrI = 32'h0; wdataI = 32'h0;
    keepRstN = 1'b0; keepReq = 1'b0; keepWe = 1'b0; keepBe = 4'h0;
    keepAddr = 32'h0; keepWdata = 32'h0;

    // Reset state of the clearing instance.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset rvalid", 32'(rvalid), 32'd0);
    checkOutput("reset err", 32'(err), 32'd0);
    checkOutput("reset rdata", rdata, 32'h0);
    checkOutput("reset busy", 32'(busy), 32'd1);
    checkOutput("reset gnt", 32'(gnt), 32'd0);

    runSweep("sweep1");

    vecs[0]  = mkVec(1, 0, 4'hF, 32'h0000_003C, 32'h0,          0, 32'h0000_0000, "read 0x3C after clear");
    vecs[1]  = mkVec(1, 1, 4'hF, 32'h0000_0010, 32'hAABB_CCDD,  0, 32'h0000_0000, "write 0x10 full");
    vecs[2]  = mkVec(1, 1, 4'h5, 32'h0000_0010, 32'h1122_3344,  0, 32'h0000_0000, "write 0x10 be=0101");
    vecs[3]  = mkVec(1, 0, 4'h0, 32'h0000_0010, 32'h0,          0, 32'hAA22_CC44, "read 0x10 merged");
    vecs[4]  = mkVec(1, 1, 4'hF, 32'h0000_0008, 32'hDEAD_BEEF,  0, 32'h0000_0000, "write 0x08");
    vecs[5]  = mkVec(1, 0, 4'h0, 32'h0000_0008, 32'h0,          0, 32'hDEAD_BEEF, "read-after-write 0x08");
    vecs[6]  = mkVec(1, 0, 4'h0, 32'h0000_0006, 32'h0,          1, 32'h0000_0000, "misaligned read 0x06");
    vecs[7]  = mkVec(1, 1, 4'hF, 32'h0000_0040, 32'h1234_5678,  1, 32'h0000_0000, "out-of-range write 0x40");
    vecs[8]  = mkVec(1, 0, 4'h0, 32'h0000_0000, 32'h0,          0, 32'h0000_0000, "reread 0x00 untouched");
    vecs[9]  = mkVec(0, 0, 4'h0, 32'h0000_0010, 32'h0,          0, 32'h0000_0000, "idle cycle");
    vecs[10] = mkVec(1, 1, 4'h0, 32'h0000_0004, 32'hFFFF_FFFF,  0, 32'h0000_0000, "be=0 write 0x04");
    vecs[11] = mkVec(1, 0, 4'h0, 32'h0000_0004, 32'h0,          0, 32'h0000_0000, "read 0x04 after no-op");
    vecs[12] = mkVec(1, 1, 4'h8, 32'h0000_000C, 32'h7766_5544,  0, 32'h0000_0000, "write 0x0C top lane");
    vecs[13] = mkVec(1, 0, 4'h0, 32'h8000_000C, 32'h0,          1, 32'h0000_0000, "out-of-range read high bit");

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].req) modelAccess(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, expErr, expRdata);
      applyStimulus(vecs[i].req, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, gntSeen);
      checkOutput({vecs[i].name, " gnt"}, 32'(gntSeen), 32'(vecs[i].req));
      checkOutput({vecs[i].name, " rvalid"}, 32'(rvalid), 32'(vecs[i].req));
      checkOutput({vecs[i].name, " err"}, 32'(err), 32'(vecs[i].expErr));
      checkOutput({vecs[i].name, " rdata"}, rdata, vecs[i].expRdata);
    end

    // Top-lane-only write must leave the other lanes at zero.
    modelAccess(1'b0, 4'h0, 32'h0000_000C, 32'h0, expErr, expRdata);
    applyStimulus(1, 0, 4'h0, 32'h0000_000C, 32'h0, gntSeen);
    checkOutput("read 0x0C top lane", rdata, 32'h7700_0000);

    // Reset mid-stream: response pending from a granted read is dropped
    // even though a request is still presented at the reset edge.
    reqI = 1'b1; weI = 1'b0; addrI = 32'h0000_0010;
    #1;
    checkOutput("midreset gnt", 32'(gnt), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("midreset first rvalid", 32'(rvalid), 32'd1);
    checkOutput("midreset first rdata", rdata, 32'hAA22_CC44);
    clrRstN = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midreset rvalid dropped", 32'(rvalid), 32'd0);
    checkOutput("midreset busy", 32'(busy), 32'd1);
    runSweep("sweep2");
    applyStimulus(1, 0, 4'h0, 32'h0000_0010, 32'h0, gntSeen);
    checkOutput("read 0x10 after resweep", rdata, 32'h0);
    checkOutput("read 0x10 after resweep err", 32'(err), 32'd0);

    // Random traffic against the reference memory.
    for (int n = 0; n < 300; n++) begin
      rReq   = ($urandom_range(0, 99) < 85);
      rWe    = $urandom_range(0, 1) == 1;
      rBe    = 4'($urandom_range(0, 15));
      rWdata = $urandom;
      case ($urandom_range(0, 9))
        0:       rAddr = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
        1:       rAddr = $urandom | 32'h0000_0040;
        default: rAddr = 32'($urandom_range(0, DEPTH - 1)) << 2;
      endcase
      expErr = 1'b0; expRdata = 32'h0;
      if (rReq) modelAccess(rWe, rBe, rAddr, rWdata, expErr, expRdata);
      applyStimulus(rReq, rWe, rBe, rAddr, rWdata, gntSeen);
      checkOutput("random gnt", 32'(gntSeen), 32'(rReq));
      checkOutput("random rvalid", 32'(rvalid), 32'(rReq));
      checkOutput("random err", 32'(err), 32'(expErr));
      checkOutput("random rdata", rdata, expRdata);
    end
    reqI = 1'b0;

    // Instance without clear sweep: RUN straight out of reset, data survives.
    keepReq = 1'b1; keepWe = 1'b1; keepBe = 4'hF;
    keepAddr = 32'h0000_0020; keepWdata = 32'hCAFE_F00D;
    keepRstN = 1'b1;
    #1;
    checkOutput("keep busy after reset", 32'(keepBusy), 32'd0);
    checkOutput("keep gnt immediate", 32'(keepGnt), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("keep write rvalid", 32'(keepRvalid), 32'd1);
    checkOutput("keep write err", 32'(keepErr), 32'd0);
    keepWe = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("keep readback", keepRdata, 32'hCAFE_F00D);
    keepReq = 1'b0;
    keepRstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("keep reset rvalid", 32'(keepRvalid), 32'd0);
    checkOutput("keep reset busy", 32'(keepBusy), 32'd0);
    checkOutput("keep gnt idle", 32'(keepGnt), 32'd0);
    keepRstN = 1'b1;
    keepReq = 1'b1;
    #1;
    checkOutput("keep gnt after reset", 32'(keepGnt), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("keep data survives reset", keepRdata, 32'hCAFE_F00D);
    checkOutput("keep survive err", 32'(keepErr), 32'd0);
    keepReq = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule : tb_dmem_ram
